imem_loader: RTL and testbench

Instruction-memory writer for the 16-bit single-cycle CPU. It accepts a byte stream from a host over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes them sequentially from word 0 into an internal instruction array, then asserts `cpu_run`. The CPU fetch side uses the same array through a zero-latency read port addressed by the byte-granular PC.

---
 rtl/imem_loader.sv | 76 +++++++
 tb/tb_imem_loader.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian host byte stream into the CPU instruction array and serves zero-latency fetches.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the CPU is released.
module imem_loader #(
    parameter int DEPTH_LOG2 = 8,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic [15:0]           Address,
    output logic [15:0]           Instruction,
    output logic                  cpu_run,
    output logic [DEPTH_LOG2:0]   words_loaded,
    output logic                  error
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LAST_WORD = (DEPTH_LOG2 + 1)'(DEPTH - 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {LOAD_HI, LOAD_LO, CHECK, RUN, ERR} state_t;
`else
    typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} state_t;
`endif
    state_t state, state_nx;
    logic [7:0] hi;
    logic [15:0] mem [DEPTH];
    logic accept, last;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic unused_addr;
    assign accept = in_valid && in_ready;
    assign last = {hi, in_data} == HALT_WORD || words_loaded == LAST_WORD;
    assign rd_idx = Address[DEPTH_LOG2:1];
    // words_loaded alone gates visibility, so the array never needs clearing
    assign Instruction = {1'b0, rd_idx} < words_loaded ? mem[rd_idx] : HALT_WORD;
    assign cpu_run = state == RUN;
    assign unused_addr = ^{Address[15:DEPTH_LOG2+1], Address[0]};
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LOAD_HI;
            hi <= '0;
            words_loaded <= '0;
        end else begin
            state <= state_nx;
            if (accept && state == LOAD_HI) hi <= in_data;
            if (accept && state == LOAD_LO) words_loaded <= words_loaded + 1'b1;
        end
    end
    always_ff @(posedge clock)
        if (accept && state == LOAD_LO) mem[words_loaded[DEPTH_LOG2-1:0]] <= {hi, in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    always_ff @(posedge clock) begin
        if (reset) csum <= '0;
        else if (accept && (state == LOAD_HI || state == LOAD_LO)) csum <= csum ^ in_data;
    end
    assign in_ready = state != RUN && state != ERR;
    assign error = state == ERR;
    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = state == LOAD_HI ? LOAD_LO :
                       state == LOAD_LO ? (last ? CHECK : LOAD_HI) :
                       state == CHECK   ? (in_data == csum ? RUN : ERR) : state;
    end
`else
    assign in_ready = state != RUN;
    assign error = 1'b0;
    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = state == LOAD_HI ? LOAD_LO :
                       state == LOAD_LO ? (last ? RUN : LOAD_HI) : state;
    end
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven fetch checks with a scoreboard queue, plus load/reset/checksum sequences.
module tb_imem_loader;
    logic clock = 0, reset = 1, in_valid = 0;
    logic [7:0] in_data = 0;
    logic [15:0] Address = 0;
    logic in_ready, cpu_run, error, in_ready4, cpu_run4, error4;
    logic [15:0] Instruction, Instruction4;
    logic [8:0] words_loaded;
    logic [2:0] words_loaded4;
    int checks = 0, passed = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        int scen;
        logic [15:0] addr;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[$];

    imem_loader #(.DEPTH_LOG2(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .Address(Address), .Instruction(Instruction), .cpu_run(cpu_run),
        .words_loaded(words_loaded), .error(error)
    );
    imem_loader #(.DEPTH_LOG2(2)) dut4 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
        .Address(Address), .Instruction(Instruction4), .cpu_run(cpu_run4),
        .words_loaded(words_loaded4), .error(error4)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1;
        in_valid = 0;
        tick;
        reset = 0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        in_valid = 1;
        in_data = b;
        tick;
        in_valid = 0;
        repeat (gap) tick;
    endtask

    // Sends n bytes (plus the XOR checksum when enabled, corrupted by flip) and checks release timing.
    task automatic load(input logic [7:0] b [8], input int n, input int gap, input logic [7:0] flip, input bit sel);
        logic [7:0] cs = 0;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) check("run_early", {15'b0, sel ? cpu_run4 : cpu_run}, 16'h0);
            cs ^= b[i];
            send(b[i], gap);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("run_before_cs", {15'b0, sel ? cpu_run4 : cpu_run}, 16'h0);
        send(cs ^ flip, gap);
        check("error", {15'b0, sel ? error4 : error}, {15'b0, flip != 0});
`endif
        check("cpu_run", {15'b0, sel ? cpu_run4 : cpu_run}, {15'b0, flip == 0});
        check("in_ready_done", {15'b0, sel ? in_ready4 : in_ready}, 16'h0);
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e, input bit sel);
        Address = a;
        exp_q.push_back(e);
        #1;
        check($sformatf("rd %h", a), sel ? Instruction4 : Instruction, exp_q.pop_front());
    endtask

    task automatic run_table(input int scen, input bit sel);
        foreach (tbl[i]) if (tbl[i].scen == scen) rd(tbl[i].addr, tbl[i].exp, sel);
    endtask

    logic [7:0] s1 [8] = '{8'h12, 8'h34, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] s3 [8] = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
    logic [7:0] s4 [8] = '{8'hAB, 8'hCD, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        tbl = '{
            '{1, 16'h0000, 16'h1234}, '{1, 16'h0002, 16'hFFFF}, '{1, 16'h0004, 16'hFFFF},
            '{1, 16'h0001, 16'h1234}, '{1, 16'h0200, 16'h1234}, '{1, 16'h0003, 16'hFFFF},
            '{1, 16'h01FE, 16'hFFFF},
            '{3, 16'h0000, 16'h0001}, '{3, 16'h0002, 16'h0002}, '{3, 16'h0004, 16'h0003},
            '{3, 16'h0006, 16'h0004}, '{3, 16'h0008, 16'h0001}, '{3, 16'h0007, 16'h0004},
            '{4, 16'h0000, 16'hABCD}, '{4, 16'h0002, 16'hFFFF}, '{4, 16'h0004, 16'hFFFF}
        };
        do_reset;
        check("rst in_ready", {15'b0, in_ready}, 16'h1);
        check("rst cpu_run", {15'b0, cpu_run}, 16'h0);
        check("rst words", {7'b0, words_loaded}, 16'h0);
        check("rst error", {15'b0, error}, 16'h0);
        check("rst in_ready4", {15'b0, in_ready4}, 16'h1);
        check("rst words4", {13'b0, words_loaded4}, 16'h0);
        rd(16'h0000, 16'hFFFF, 0);

        load(s1, 4, 0, 8'h00, 0);
        check("s1 words", {7'b0, words_loaded}, 16'd2);
        run_table(1, 0);

        do_reset;
        load(s1, 4, 5, 8'h00, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        send(8'hCC, 2);
        check("s2 words", {7'b0, words_loaded}, 16'd2);
        check("s2 cpu_run", {15'b0, cpu_run}, 16'h1);
        run_table(1, 0);

        do_reset;
        load(s3, 8, 0, 8'h00, 1);
        check("s3 words4", {13'b0, words_loaded4}, 16'd4);
        send(8'h55, 0);
        check("s3 9th words4", {13'b0, words_loaded4}, 16'd4);
        check("s3 9th run4", {15'b0, cpu_run4}, 16'h1);
        run_table(3, 1);

        do_reset;
        send(8'h12, 0);
        send(8'h34, 0);
        send(8'h56, 0);
        check("s4 partial words", {7'b0, words_loaded}, 16'd1);
        do_reset;
        check("s4 rst words", {7'b0, words_loaded}, 16'h0);
        check("s4 rst in_ready", {15'b0, in_ready}, 16'h1);
        check("s4 rst cpu_run", {15'b0, cpu_run}, 16'h0);
        load(s4, 4, 0, 8'h00, 0);
        check("s4 words", {7'b0, words_loaded}, 16'd2);
        run_table(4, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset;
        load(s1, 4, 0, 8'h01, 0);
        send(8'h26, 1);
        check("cs err hold", {15'b0, error}, 16'h1);
        check("cs err run", {15'b0, cpu_run}, 16'h0);
        check("cs err ready", {15'b0, in_ready}, 16'h0);
        check("cs err words", {7'b0, words_loaded}, 16'd2);
        do_reset;
        check("cs rst error", {15'b0, error}, 16'h0);
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
